// File: rtl/wb_commit_stage_pkg.sv
// Shared constants for the write-back/commit stage: ECODE values, exception
// vector bit positions, bundle field widths and the squash FSM encoding.
package wb_commit_stage_pkg;

    localparam int PC_W      = 32;
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;
    localparam int CSR_NUM_W = 14;
    localparam int ECODE_W   = 6;
    localparam int SQ_CNT_W  = 3;

    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_PIL  = 6'h01;
    localparam logic [ECODE_W-1:0] ECODE_PIS  = 6'h02;
    localparam logic [ECODE_W-1:0] ECODE_PIF  = 6'h03;
    localparam logic [ECODE_W-1:0] ECODE_PME  = 6'h04;
    localparam logic [ECODE_W-1:0] ECODE_PPI  = 6'h07;
    localparam logic [ECODE_W-1:0] ECODE_ADE  = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
    localparam logic [ECODE_W-1:0] ECODE_IPE  = 6'h0E;
    localparam logic [ECODE_W-1:0] ECODE_TLBR = 6'h3F;

    // Bit positions in the 16-wide exception vector (fetch-side causes sit above memory-side ones).
    localparam int EXCP_INT    = 15;
    localparam int EXCP_ADE    = 14;
    localparam int EXCP_TLBR_F = 13;
    localparam int EXCP_PIF    = 12;
    localparam int EXCP_PPI_F  = 11;
    localparam int EXCP_SYS    = 10;
    localparam int EXCP_BRK    = 9;
    localparam int EXCP_INE    = 8;
    localparam int EXCP_IPE    = 7;
    localparam int EXCP_ALE    = 6;
    localparam int EXCP_TLBR_M = 5;
    localparam int EXCP_PME    = 4;
    localparam int EXCP_PPI_M  = 3;
    localparam int EXCP_PIS    = 2;
    localparam int EXCP_PIL    = 1;

    typedef enum logic {
        WS_RUN    = 1'b0,
        WS_SQUASH = 1'b1
    } ws_state_t;

    // pos = distance from the MSB of the vector, so narrower vectors keep the same priority order.
    function automatic logic [ECODE_W-1:0] excp_pos_ecode(input int pos);
        case (pos)
            15 - EXCP_INT:    return ECODE_INT;
            15 - EXCP_ADE:    return ECODE_ADE;
            15 - EXCP_TLBR_F: return ECODE_TLBR;
            15 - EXCP_PIF:    return ECODE_PIF;
            15 - EXCP_PPI_F:  return ECODE_PPI;
            15 - EXCP_SYS:    return ECODE_SYS;
            15 - EXCP_BRK:    return ECODE_BRK;
            15 - EXCP_INE:    return ECODE_INE;
            15 - EXCP_IPE:    return ECODE_IPE;
            15 - EXCP_ALE:    return ECODE_ALE;
            15 - EXCP_TLBR_M: return ECODE_TLBR;
            15 - EXCP_PME:    return ECODE_PME;
            15 - EXCP_PPI_M:  return ECODE_PPI;
            15 - EXCP_PIS:    return ECODE_PIS;
            15 - EXCP_PIL:    return ECODE_PIL;
            default:          return 6'h00;
        endcase
    endfunction

endpackage

// File: rtl/wb_commit_stage_excp_encoder.sv
// One-hot exception vector to ECODE priority encoder; the highest set bit wins.
module wb_commit_stage_excp_encoder
    import wb_commit_stage_pkg::*;
#(
    parameter int EXCP_W = 16
) (
    input  logic [EXCP_W-1:0]  excp_num,
    output logic [ECODE_W-1:0] ecode
);

    always_comb begin
        ecode = 6'h00;
        // Ascending scan so the most significant set bit overrides lower ones.
        for (int k = 0; k < EXCP_W; k++) begin
            if (excp_num[k]) ecode = excp_pos_ecode(EXCP_W - 1 - k);
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane write-back/commit stage: in-order commit, exception/ertn flush,
// post-flush squash window, same-destination resolution and instret counting.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int LANES         = 2,
    parameter int EXCP_W        = 16,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic                              ws_allowin,
    input  logic                              ms_to_ws_valid,
    input  logic [LANES-1:0]                  ms_lane_valid,
    input  logic [LANES-1:0][PC_W-1:0]        ms_pc,
    input  logic [LANES-1:0][REG_W-1:0]       ms_dest,
    input  logic [LANES-1:0]                  ms_gr_we,
    input  logic [LANES-1:0][DATA_W-1:0]      ms_result,
    input  logic [LANES-1:0][EXCP_W-1:0]      ms_excp_num,
    input  logic [LANES-1:0][PC_W-1:0]        ms_badv,
    input  logic                              ms_ertn,
    input  logic                              ms_res_from_csr,
    input  logic                              ms_csr_we,
    input  logic [CSR_NUM_W-1:0]              ms_csr_num,
    input  logic [DATA_W-1:0]                 ms_csr_wmask,
    input  logic [DATA_W-1:0]                 ms_csr_wdata,
    input  logic [DATA_W-1:0]                 csr_rdata,
    output logic                              csr_we,
    output logic [CSR_NUM_W-1:0]              csr_num,
    output logic [DATA_W-1:0]                 csr_wmask,
    output logic [DATA_W-1:0]                 csr_wdata,
    output logic                              excp_flush,
    output logic                              ertn_flush,
    output logic [ECODE_W-1:0]                ecode,
    output logic [2:0]                        esubcode,
    output logic [PC_W-1:0]                   epc,
    output logic [PC_W-1:0]                   eaddr,
    output logic [LANES-1:0]                  rf_we,
    output logic [LANES-1:0][REG_W-1:0]       rf_waddr,
    output logic [LANES-1:0][DATA_W-1:0]      rf_wdata,
    output logic [LANES-1:0]                  fwd_valid,
    output logic [63:0]                       instret,
    output logic [LANES-1:0][PC_W-1:0]        debug_wb_pc,
    output logic [LANES-1:0][3:0]             debug_wb_rf_we,
    output logic [LANES-1:0][REG_W-1:0]       debug_wb_rf_wnum,
    output logic [LANES-1:0][DATA_W-1:0]      debug_wb_rf_wdata
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [SQ_CNT_W-1:0] SQ_INIT = SQ_CNT_W'(SQUASH_CYCLES);

    logic                         ws_valid;
    logic                         ws_ready_go;
    logic [LANES-1:0]             lane_vld;
    logic [LANES-1:0][PC_W-1:0]   pc_r;
    logic [LANES-1:0][REG_W-1:0]  dest_r;
    logic [LANES-1:0]             gr_we_r;
    logic [LANES-1:0][DATA_W-1:0] result_r;
    logic [LANES-1:0][EXCP_W-1:0] excp_r;
    logic [LANES-1:0][PC_W-1:0]   badv_r;
    logic                         ertn_r;
    logic                         res_from_csr_r;
    logic                         csr_we_r;
    logic [CSR_NUM_W-1:0]         csr_num_r;
    logic [DATA_W-1:0]            csr_wmask_r;
    logic [DATA_W-1:0]            csr_wdata_r;

    ws_state_t                    state, state_nx;
    logic [SQ_CNT_W-1:0]          sq_cnt, sq_cnt_nx;

    logic [LANES-1:0]             lane_valid;
    logic [LANES-1:0]             lane_excp;
    logic [LANES-1:0]             kill;
    logic [LANES-1:0]             commit;
    logic [LANES-1:0]             gr_commit;
    logic [LW-1:0]                fault_lane;
    logic                         ertn_live;
    logic                         excp_seen;
    logic [2:0]                   ret_cnt;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    // A bundle landing while the stage is (or is about to be) squashing is kept as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid       <= 1'b0;
            lane_vld       <= '0;
            pc_r           <= '0;
            dest_r         <= '0;
            gr_we_r        <= '0;
            result_r       <= '0;
            excp_r         <= '0;
            badv_r         <= '0;
            ertn_r         <= 1'b0;
            res_from_csr_r <= 1'b0;
            csr_we_r       <= 1'b0;
            csr_num_r      <= '0;
            csr_wmask_r    <= '0;
            csr_wdata_r    <= '0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                lane_vld       <= (state_nx == WS_SQUASH) ? '0 : ms_lane_valid;
                pc_r           <= ms_pc;
                dest_r         <= ms_dest;
                gr_we_r        <= ms_gr_we;
                result_r       <= ms_result;
                excp_r         <= ms_excp_num;
                badv_r         <= ms_badv;
                ertn_r         <= ms_ertn;
                res_from_csr_r <= ms_res_from_csr;
                csr_we_r       <= ms_csr_we;
                csr_num_r      <= ms_csr_num;
                csr_wmask_r    <= ms_csr_wmask;
                csr_wdata_r    <= ms_csr_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= WS_RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_nx;
            sq_cnt <= sq_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sq_cnt_nx = sq_cnt;
        case (state)
            WS_RUN: begin
                if (excp_flush || ertn_flush) begin
                    state_nx  = WS_SQUASH;
                    sq_cnt_nx = SQ_INIT;
                end
            end
            WS_SQUASH: begin
                sq_cnt_nx = sq_cnt - 1'b1;
                if (sq_cnt <= 1) state_nx = WS_RUN;
            end
            default: state_nx = WS_RUN;
        endcase
    end

    always_comb begin
        lane_valid = lane_vld & {LANES{ws_valid}};
        for (int i = 0; i < LANES; i++) lane_excp[i] = lane_valid[i] && (|excp_r[i]);

        fault_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_excp[i]) fault_lane = LW'(i);
        end

        ertn_live = lane_valid[0] && ertn_r;
        excp_seen = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            kill[i]   = excp_seen || ((i > 0) && ertn_live);
            excp_seen = excp_seen || lane_excp[i];
        end

        commit    = lane_valid & ~lane_excp & ~kill;
        gr_commit = commit & gr_we_r;

        // Younger lane wins a shared nonzero destination; r0 writes pass through untouched.
        for (int i = 0; i < LANES; i++) begin
            rf_we[i] = gr_commit[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (gr_commit[j] && (dest_r[j] == dest_r[i]) && (dest_r[i] != '0)) rf_we[i] = 1'b0;
            end
        end

        ret_cnt = '0;
        for (int i = 0; i < LANES; i++) ret_cnt = ret_cnt + {2'b00, commit[i]};
    end

    always_ff @(posedge clk) begin
        if (reset) instret <= '0;
        else       instret <= instret + 64'(ret_cnt);
    end

    wb_commit_stage_excp_encoder #(.EXCP_W(EXCP_W)) u_excp_encoder (
        .excp_num (excp_r[fault_lane]),
        .ecode    (ecode)
    );

    assign excp_flush = |lane_excp;
    assign ertn_flush = ertn_live && !lane_excp[0];
    assign esubcode   = 3'd0;
    assign epc        = pc_r[fault_lane];
    assign eaddr      = badv_r[fault_lane];

    assign csr_we     = csr_we_r && lane_valid[0] && !lane_excp[0];
    assign csr_num    = csr_num_r;
    assign csr_wmask  = csr_wmask_r;
    assign csr_wdata  = csr_wdata_r;

    assign rf_waddr   = dest_r;
    assign fwd_valid  = lane_valid & gr_we_r;

    always_comb begin
        rf_wdata = result_r;
        if (res_from_csr_r) rf_wdata[0] = csr_rdata;
        for (int i = 0; i < LANES; i++) begin
            debug_wb_pc[i]       = pc_r[i];
            debug_wb_rf_we[i]    = {4{rf_we[i]}};
            debug_wb_rf_wnum[i]  = dest_r[i];
            debug_wb_rf_wdata[i] = rf_wdata[i];
        end
    end

endmodule
